sram_controller: RTL and testbench

Bridges the 32-bit memory stage of the ARM pipeline to the external 16-bit-wide SRAM (18-bit halfword address bus). Each word load or store becomes two sequential halfword accesses, low half first. While an access is in flight, `ready` is deasserted so the pipeline freezes. The block sits between the memory stage (consumer of `read_data`/`ready`) and the SRAM pins driven by `TopLevel`.

---
 rtl/sram_controller.sv | 156 +++++++++++++++
 tb/tb_sram_controller.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// sram_controller
//   Bridges the 32-bit memory stage to a 16-bit external SRAM. Each word
//   access is split into two halfword accesses, low half first. Each half is
//   held on the pins for WAIT_CYCLES cycles. While the split access is in
//   flight, ready is low so the pipeline freezes.
//
//   Handshake: a request (wr_en | rd_en) is taken in IDLE. ready drops
//   combinationally in that same cycle. ready stays low through LOW and HIGH.
//   It returns high for exactly one DONE cycle, in which the pipeline advances
//   and new requests are ignored. The next request is taken in the following
//   IDLE cycle.
//
// Parameters
//   WAIT_CYCLES : cycles each halfword is held on the SRAM pins (>= 1)
//   BASE_ADDR   : CPU byte address that maps to SRAM word 0
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   wr_en, rd_en      : store / load request (store wins if both)
//   address           : CPU byte address
//   write_data        : store data
//   read_data         : registered load result
//   ready             : 0 = freeze pipeline
//   SRAM_DQ           : bidirectional SRAM data bus
//   SRAM_ADDR         : SRAM halfword address
//   SRAM_UB_N/LB_N/CE_N : tied active
//   SRAM_WE_N, SRAM_OE_N: write strobe / output enable, active low
//   state_dbg         : current FSM state (IDLE=0, LOW=1, HIGH=2, DONE=3)
module sram_controller #(
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   inout  wire  [15:0] SRAM_DQ,
   output logic [17:0] SRAM_ADDR,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N,
   output logic        SRAM_CE_N,
   output logic        SRAM_WE_N,
   output logic        SRAM_OE_N,
   output logic [1:0]  state_dbg
);

   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             op_wr;
   logic [16:0]      word_q;
   logic [31:0]      wdata_q;

   logic        req;
   logic        last;
   logic [31:0] off;
   logic        dq_oe;
   logic [15:0] dq_out;
   logic        unused_off_bits;

   assign req  = wr_en | rd_en;
   assign last = (cnt == CNT_LAST);
   // Modular subtraction: addresses below BASE_ADDR wrap, only [18:2] matter.
   assign off  = address - BASE_ADDR;
   assign unused_off_bits = ^{off[31:19], off[1:0]};

   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;
   assign SRAM_CE_N = 1'b0;
   assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
   assign state_dbg = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ready     = 1'b0;
      SRAM_WE_N = 1'b1;
      SRAM_OE_N = 1'b1;
      SRAM_ADDR = '0;
      dq_oe     = 1'b0;
      dq_out    = '0;
      case (state)
         IDLE: begin
            ready = ~req;
            if (req) begin
               state_nxt = LOW;
               cnt_nxt   = '0;
            end
         end
         LOW, HIGH: begin
            SRAM_ADDR = {word_q, (state == HIGH)};
            SRAM_WE_N = ~op_wr;
            SRAM_OE_N = op_wr;
            dq_oe     = op_wr;
            dq_out    = (state == HIGH) ? wdata_q[31:16] : wdata_q[15:0];
            if (last) begin
               state_nxt = (state == HIGH) ? DONE : HIGH;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         DONE: begin
            ready     = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // Reset forces ready high even while a request is presented.
      if (rst) ready = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_wr     <= 1'b0;
         word_q    <= '0;
         wdata_q   <= '0;
         read_data <= '0;
      end else begin
         if (state == IDLE && req) begin
            op_wr   <= wr_en;
            word_q  <= off[18:2];
            wdata_q <= write_data;
         end
         // Sample the bus on the final cycle of each read phase, when SRAM
         // data has had the full wait window to settle.
         if (!op_wr && last) begin
            if (state == LOW)  read_data[15:0]  <= SRAM_DQ;
            if (state == HIGH) read_data[31:16] <= SRAM_DQ;
         end
      end
   end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller with WAIT_CYCLES=2 and BASE_ADDR=1024.
// A behavioral SRAM model sits on the pins. A pull-up on DQ makes an
// undriven bus read as 16'hFFFF.
module tb_sram_controller;

   localparam logic [15:0] DQ_FLOAT = 16'hFFFF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic        rd_en = 1'b0;
   logic [31:0] address = '0;
   logic [31:0] write_data = '0;
   logic [31:0] read_data;
   logic        ready;
   wire  [15:0] SRAM_DQ;
   logic [17:0] SRAM_ADDR;
   logic        SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_WE_N, SRAM_OE_N;
   logic [1:0]  state_dbg;

   sram_controller #(.WAIT_CYCLES(2), .BASE_ADDR(32'd1024)) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .rd_en      (rd_en),
      .address    (address),
      .write_data (write_data),
      .read_data  (read_data),
      .ready      (ready),
      .SRAM_DQ    (SRAM_DQ),
      .SRAM_ADDR  (SRAM_ADDR),
      .SRAM_UB_N  (SRAM_UB_N),
      .SRAM_LB_N  (SRAM_LB_N),
      .SRAM_CE_N  (SRAM_CE_N),
      .SRAM_WE_N  (SRAM_WE_N),
      .SRAM_OE_N  (SRAM_OE_N),
      .state_dbg  (state_dbg)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- SRAM model ----------------
   logic [15:0] mem [0:63];

   for (genvar i = 0; i < 16; i++) begin : g_pu
      pullup pu (SRAM_DQ[i]);
   end

   assign SRAM_DQ = (!SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR[5:0]] : 16'hzzzz;

   always @(negedge clk) begin
      if (!SRAM_WE_N && !SRAM_CE_N) mem[SRAM_ADDR[5:0]] = SRAM_DQ;
   end

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad = 0;
   logic [31:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---------------- access driver / monitor ----------------
   int          stall, we_lo, oe_lo;
   logic [17:0] addr_q[$];
   logic        done_seen;
   logic [15:0] done_dq;
   logic [31:0] done_rd;

   task automatic run_access(input logic wr, input logic rd,
                             input logic [31:0] a, input logic [31:0] d);
      stall = 0; we_lo = 0; oe_lo = 0; done_seen = 1'b0;
      addr_q.delete();
      wr_en = wr; rd_en = rd; address = a; write_data = d;
      for (int c = 0; c < 20 && !done_seen; c++) begin
         @(negedge clk);
         if (!ready) stall++;
         else if (c > 0) begin
            done_seen = 1'b1;
            done_dq   = SRAM_DQ;
            done_rd   = read_data;
         end
         if (!SRAM_WE_N) we_lo++;
         if (!SRAM_OE_N) oe_lo++;
         if (!SRAM_WE_N || !SRAM_OE_N) addr_q.push_back(SRAM_ADDR);
         @(posedge clk); #1;
         wr_en = 1'b0; rd_en = 1'b0;
      end
      chk("done_timeout", {31'd0, done_seen}, 32'd1);
   endtask

   task automatic chk_addrs(input string tag, input logic [17:0] a0, input logic [17:0] a1);
      logic [17:0] e [4];
      e[0] = a0; e[1] = a0; e[2] = a1; e[3] = a1;
      chk({tag, "_n"}, addr_q.size(), 4);
      for (int k = 0; k < 4; k++)
         chk(tag, (k < addr_q.size()) ? 32'(addr_q[k]) : 32'hFFFF_FFFF, 32'(e[k]));
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 16'h0000;

      // Reset state, with a request present to show ready is forced high.
      rd_en = 1'b1; address = 32'd1024;
      #2;
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_we",    {31'd0, SRAM_WE_N}, 32'd1);
      chk("rst_oe",    {31'd0, SRAM_OE_N}, 32'd1);
      chk("rst_dq",    {16'd0, SRAM_DQ}, {16'd0, DQ_FLOAT});
      chk("rst_addr",  {14'd0, SRAM_ADDR}, 32'd0);
      chk("rst_rdata", read_data, 32'd0);
      chk("rst_state", {30'd0, state_dbg}, 32'd0);
      chk("tie_n",     {29'd0, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N}, 32'd0);
      rd_en = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;

      // Store 0xDEADBEEF at 1024.
      run_access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
      chk("st0_stall", stall, 5);
      chk("st0_we",    we_lo, 4);
      chk("st0_oe",    oe_lo, 0);
      chk("st0_dq",    {16'd0, done_dq}, {16'd0, DQ_FLOAT});
      chk_addrs("st0_addr", 18'd0, 18'd1);
      chk("st0_mem0",  {16'd0, mem[0]}, 32'h0000BEEF);
      chk("st0_mem1",  {16'd0, mem[1]}, 32'h0000DEAD);

      // Load it back.
      exp_q.push_back(32'hDEADBEEF);
      run_access(1'b0, 1'b1, 32'd1024, 32'd0);
      chk("ld0_stall", stall, 5);
      chk("ld0_oe",    oe_lo, 4);
      chk("ld0_we",    we_lo, 0);
      chk_addrs("ld0_addr", 18'd0, 18'd1);
      chk("ld0_data",  done_rd, exp_q.pop_front());

      // Back-to-back store then load at 1032 (word 2 -> halfwords 4,5).
      run_access(1'b1, 1'b0, 32'd1032, 32'h12345678);
      chk("st1_stall", stall, 5);
      chk_addrs("st1_addr", 18'd4, 18'd5);
      exp_q.push_back(32'h12345678);
      run_access(1'b0, 1'b1, 32'd1032, 32'd0);
      chk("ld1_stall", stall, 5);
      chk_addrs("ld1_addr", 18'd4, 18'd5);
      chk("ld1_data",  done_rd, exp_q.pop_front());

      // Both requests at 1028: store wins, read_data untouched.
      run_access(1'b1, 1'b1, 32'd1028, 32'hCAFEF00D);
      chk("both_we",    we_lo, 4);
      chk("both_oe",    oe_lo, 0);
      chk_addrs("both_addr", 18'd2, 18'd3);
      chk("both_rdata", read_data, 32'h12345678);
      chk("both_mem2",  {16'd0, mem[2]}, 32'h0000F00D);
      chk("both_mem3",  {16'd0, mem[3]}, 32'h0000CAFE);

      // Reset during HIGH of a store to 1040 (halfwords 8,9).
      wr_en = 1'b1; address = 32'd1040; write_data = 32'hAAAA5555;
      @(posedge clk); #1; wr_en = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("mid_state", {30'd0, state_dbg}, 32'd2);
      chk("mid_we",    {31'd0, SRAM_WE_N}, 32'd0);
      rst = 1'b1;
      #1;
      chk("abort_we",    {31'd0, SRAM_WE_N}, 32'd1);
      chk("abort_dq",    {16'd0, SRAM_DQ}, {16'd0, DQ_FLOAT});
      chk("abort_ready", {31'd0, ready}, 32'd1);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      chk("post_state", {30'd0, state_dbg}, 32'd0);
      chk("post_ready", {31'd0, ready}, 32'd1);
      chk("post_mem8",  {16'd0, mem[8]}, 32'h00005555);
      chk("post_mem9",  {16'd0, mem[9]}, 32'h00000000);
      chk("post_rdata", read_data, 32'd0);

      // The half-written word reads back with only its low half.
      exp_q.push_back(32'h00005555);
      run_access(1'b0, 1'b1, 32'd1040, 32'd0);
      chk("ld2_data", done_rd, exp_q.pop_front());

      // Idle for 20 cycles.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle", {13'd0, ready, SRAM_WE_N, SRAM_OE_N, SRAM_DQ},
             {13'd0, 3'b111, DQ_FLOAT});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
